adc_sequencer: RTL and testbench
================================

ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max clk cycles in WAIT before a conversion is abandoned.
REQ-002 Parameter DATA_W, default 12: sample width.
REQ-003 clk  input  1  system clock (12.5 MHz domain), all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low; one clock; no other clock or reset.
REQ-005 sample_tick  input  1  one-cycle pacing strobe requesting a conversion.
REQ-006 mode  input  2  00 = ch1 only, 01 = ch2 only, 10 = alternate ch1/ch2, 11 = hold (no conversions).
REQ-007 conv_start  output  1  one-cycle pulse launching a serial conversion.
REQ-008 conv_sel  output  1  channel select to serial interface: 1 = ch1, 0 = ch2.
REQ-009 conv_done  input  1  one-cycle pulse from serial interface: conv_data valid.
REQ-010 conv_data  input  DATA_W  converted sample.
REQ-011 ch1_sample, ch2_sample  output  DATA_W each  last captured sample per channel.
REQ-012 ch1_valid, ch2_valid  output  1 each  one-cycle pulse when the matching sample register updates.
REQ-013 overrun  output  1  sticky: sample_tick arrived while not IDLE.
REQ-014 timeout_err  output  1  sticky: conversion abandoned on timeout.
REQ-015 err_clr  input  1  clears overrun and timeout_err.
REQ-016 ch1_peak, ch2_peak  output  DATA_W each  peak-hold value (see Configuration).
REQ-017 peak_decay  input  1  one-cycle strobe decrementing both peaks.

Function
REQ-018 FSM states IDLE, START, WAIT, CAPTURE; encoding from package.
REQ-019 IDLE: sample_tick=1 and mode!=11 -> START next cycle; otherwise stay.
REQ-020 START: conv_start=1 for exactly this cycle; conv_sel latched here from mode/next-channel and held stable through WAIT and CAPTURE; -> WAIT.
REQ-021 WAIT: conv_done=1 -> CAPTURE, conv_data registered into channel-selected capture reg this same edge; cycle counter reaching TIMEOUT_CYCLES -> IDLE with timeout_err set, no sample update.
REQ-022 CAPTURE: selected chN_sample updated, chN_valid pulses one cycle; -> IDLE.
REQ-023 Latency sample_tick -> conv_start = 1 cycle; conv_done -> chN_valid = 2 cycles.
REQ-024 conv_done outside WAIT ignored.
REQ-025 Alternate mode: next channel toggles after every CAPTURE and every timeout; first channel after reset = ch1.
REQ-026 mode changes take effect only at the next START; in-flight conversion completes on its latched channel.
REQ-027 sample_tick in START/WAIT/CAPTURE dropped, overrun set; no queueing.
REQ-028 err_clr and a new error event same cycle: error wins (flag stays 1).
REQ-029 Never both chN_valid high in one cycle.

Reset
REQ-030 reset_n=0 asynchronously forces: state IDLE, conv_start=0, conv_sel=1, all samples/peaks 0, valid pulses 0, overrun=0, timeout_err=0, next channel ch1, timeout counter 0.
REQ-031 Reset mid-conversion abandons it; any later conv_done is ignored (state IDLE).

Configuration
REQ-032 Macro ADC_SEQ_PEAK_EN defined: per channel, on capture peak <= max(sample, peak); on peak_decay peak <= peak-1 saturating at 0; both same cycle: peak <= max(sample, sat(peak-1)).
REQ-033 Macro undefined: no peak logic; ch1_peak/ch2_peak tied 0; peak_decay ignored.

Structure
REQ-034 Package adc_seq_pkg holds FSM state type, mode encodings (MODE_CH1, MODE_CH2, MODE_ALT, MODE_HOLD), channel select constants.
REQ-035 Sub-module adc_seq_peak (one per channel, DATA_W parameter) implements REQ-032; instantiated only under ADC_SEQ_PEAK_EN.

Verification
REQ-036 mode=00, tick, conv_done with data 0xABC 5 cycles after conv_start -> conv_sel=1 throughout, ch1_sample=0xABC, ch1_valid single pulse 2 cycles after conv_done.
REQ-037 mode=10, three ticks each completed (data 0x100, 0x200, 0x300) -> ch1=0x300, ch2=0x200, conv_sel sequence 1,0,1.
REQ-038 TIMEOUT_CYCLES=64, no conv_done -> IDLE after 64 WAIT cycles, timeout_err=1, samples unchanged; err_clr -> 0.
REQ-039 tick during WAIT -> overrun=1, no second conv_start; reset_n low during WAIT then late conv_done -> no valid pulse, all outputs at reset values.
REQ-040 ADC_SEQ_PEAK_EN: ch1 captures 0x800 then 0x400 -> peak 0x800; peak_decay concurrent with capture 0x7FF at peak 0x800 -> peak 0x7FF; decay at 0 stays 0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// ---------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the ADC conversion sequencer:
//   - seq_state_t : FSM state type (IDLE, START, WAIT, CAPTURE)
//   - MODE_*      : encodings of the 2-bit mode input
//   - SEL_*       : values driven on conv_sel (1 = ch1, 0 = ch2)
//   - select_channel() : channel chosen for a new conversion
// ---------------------------------------------------------------------------
package adc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } seq_state_t;

    localparam logic [1:0] MODE_CH1  = 2'b00;
    localparam logic [1:0] MODE_CH2  = 2'b01;
    localparam logic [1:0] MODE_ALT  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam logic SEL_CH1 = 1'b1;
    localparam logic SEL_CH2 = 1'b0;

    // Channel for a conversion launched now; next_ch only matters in MODE_ALT.
    function automatic logic select_channel(input logic [1:0] mode, input logic next_ch);
        case (mode)
            MODE_CH1: return SEL_CH1;
            MODE_CH2: return SEL_CH2;
            default:  return next_ch;
        endcase
    endfunction

endpackage

// File: rtl/adc_seq_if.sv
// ---------------------------------------------------------------------------
// adc_seq_if
// Handshake between the sequencer and the serial ADC interface.
//   conv_start : one-cycle pulse launching a conversion (sequencer -> ADC)
//   conv_sel   : channel select, 1 = ch1, 0 = ch2       (sequencer -> ADC)
//   conv_done  : one-cycle pulse, conv_data valid        (ADC -> sequencer)
//   conv_data  : converted sample, DATA_W bits           (ADC -> sequencer)
// Modports: master = sequencer side, slave = serial interface side.
// ---------------------------------------------------------------------------
interface adc_seq_if #(
    parameter int DATA_W = 12
);
    logic              conv_start;
    logic              conv_sel;
    logic              conv_done;
    logic [DATA_W-1:0] conv_data;

    modport master (output conv_start, output conv_sel,
                    input  conv_done,  input  conv_data);
    modport slave  (input  conv_start, input  conv_sel,
                    output conv_done,  output conv_data);
endinterface

// File: rtl/adc_seq_peak.sv
// ---------------------------------------------------------------------------
// adc_seq_peak
// Per-channel peak-hold register with saturating decay.
//   clk, reset_n : clock, asynchronous active-low reset
//   capture      : a new sample is being written this edge
//   sample       : value being captured
//   decay        : decrement the peak by one (saturates at 0)
//   peak         : held peak value
// With capture and decay together: peak <= max(sample, sat(peak - 1)).
// ---------------------------------------------------------------------------
module adc_seq_peak #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture,
    input  logic              decay,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] peak
);
    logic [DATA_W-1:0] decayed;
    logic [DATA_W-1:0] peak_nxt;

    always_comb begin
        decayed = peak;
        if (decay && (peak != '0)) decayed = peak - DATA_W'(1);
        peak_nxt = decayed;
        if (capture && (sample > decayed)) peak_nxt = sample;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) peak <= '0;
        else          peak <= peak_nxt;
    end
endmodule

// File: rtl/adc_sequencer.sv
// ---------------------------------------------------------------------------
// adc_sequencer
// Paces serial ADC conversions from sample_tick and stores results per channel.
//   clk, reset_n           : clock, asynchronous active-low reset
//   sample_tick            : one-cycle conversion request
//   mode                   : 00 ch1, 01 ch2, 10 alternate, 11 hold
//   conv (adc_seq_if.master): conv_start/conv_sel out, conv_done/conv_data in
//   ch1_sample, ch2_sample : last captured sample per channel
//   ch1_valid, ch2_valid   : one-cycle pulse when the sample register updates
//   overrun, timeout_err   : sticky error flags, cleared by err_clr
//   ch1_peak, ch2_peak     : peak-hold values (0 unless ADC_SEQ_PEAK_EN)
//   peak_decay             : decrement both peaks (ADC_SEQ_PEAK_EN only)
// Build option: define ADC_SEQ_PEAK_EN to include the peak-hold logic.
// ---------------------------------------------------------------------------
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DATA_W         = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic [1:0]        mode,
    adc_seq_if.master         conv,
    output logic [DATA_W-1:0] ch1_sample,
    output logic [DATA_W-1:0] ch2_sample,
    output logic              ch1_valid,
    output logic              ch2_valid,
    output logic              overrun,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [DATA_W-1:0] ch1_peak,
    output logic [DATA_W-1:0] ch2_peak,
    input  logic              peak_decay
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t        state;
    logic              conv_start_q;
    logic              conv_sel_q;
    logic              next_ch;
    logic              alt_q;       // current conversion was launched in MODE_ALT
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] cap_q;

    assign conv.conv_start = conv_start_q;
    assign conv.conv_sel   = conv_sel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            conv_start_q <= 1'b0;
            conv_sel_q   <= SEL_CH1;
            next_ch      <= SEL_CH1;
            alt_q        <= 1'b0;
            wait_cnt     <= '0;
            cap_q        <= '0;
            ch1_sample   <= '0;
            ch2_sample   <= '0;
            ch1_valid    <= 1'b0;
            ch2_valid    <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            conv_start_q <= 1'b0;
            ch1_valid    <= 1'b0;
            ch2_valid    <= 1'b0;

            // Clear first; error events below are later assignments and win.
            if (err_clr) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (sample_tick && (state != ST_IDLE)) overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (sample_tick && (mode != MODE_HOLD)) begin
                        state        <= ST_START;
                        conv_start_q <= 1'b1;
                        conv_sel_q   <= select_channel(mode, next_ch);
                        alt_q        <= (mode == MODE_ALT);
                    end
                end
                ST_START: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (conv.conv_done) begin
                        cap_q <= conv.conv_data;
                        state <= ST_CAPTURE;
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                        if (alt_q) next_ch <= ~conv_sel_q;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (conv_sel_q == SEL_CH1) begin
                        ch1_sample <= cap_q;
                        ch1_valid  <= 1'b1;
                    end else begin
                        ch2_sample <= cap_q;
                        ch2_valid  <= 1'b1;
                    end
                    if (alt_q) next_ch <= ~conv_sel_q;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADC_SEQ_PEAK_EN
    // Peaks update on the same edge as the sample registers.
    logic cap1;
    logic cap2;
    assign cap1 = (state == ST_CAPTURE) && (conv_sel_q == SEL_CH1);
    assign cap2 = (state == ST_CAPTURE) && (conv_sel_q == SEL_CH2);

    adc_seq_peak #(.DATA_W(DATA_W)) u_peak1 (
        .clk     (clk),
        .reset_n (reset_n),
        .capture (cap1),
        .decay   (peak_decay),
        .sample  (cap_q),
        .peak    (ch1_peak)
    );
    adc_seq_peak #(.DATA_W(DATA_W)) u_peak2 (
        .clk     (clk),
        .reset_n (reset_n),
        .capture (cap2),
        .decay   (peak_decay),
        .sample  (cap_q),
        .peak    (ch2_peak)
    );
`else
    logic unused_peak_decay;
    assign unused_peak_decay = peak_decay;
    assign ch1_peak = '0;
    assign ch2_peak = '0;
`endif
endmodule

// File: tb/tb_adc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_sequencer
// Randomized scoreboard bench for adc_sequencer. The driver issues
// conversions and pushes expected (channel, data, due cycle) records; a
// negedge monitor pops them when a valid pulse appears and tracks the
// expected sample/peak registers. Peak expectations honour ADC_SEQ_PEAK_EN.
// ---------------------------------------------------------------------------
module tb_adc_sequencer;
    import adc_seq_pkg::*;

    localparam int DW = 12;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sample_tick;
    logic [1:0]    mode;
    logic          err_clr;
    logic          peak_decay;
    logic [DW-1:0] ch1_sample, ch2_sample, ch1_peak, ch2_peak;
    logic          ch1_valid, ch2_valid, overrun, timeout_err;

    adc_seq_if #(.DATA_W(DW)) conv_if ();

    adc_sequencer #(.TIMEOUT_CYCLES(TO), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .mode        (mode),
        .conv        (conv_if),
        .ch1_sample  (ch1_sample),
        .ch2_sample  (ch2_sample),
        .ch1_valid   (ch1_valid),
        .ch2_valid   (ch2_valid),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .ch1_peak    (ch1_peak),
        .ch2_peak    (ch2_peak),
        .peak_decay  (peak_decay)
    );

    always #40 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic          sel;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t exp_q[$];

    // Reference state
    logic          nxt;        // next channel for alternate mode
    bit            exp_ovr, exp_terr;
    logic [DW-1:0] ms1, ms2;   // expected sample registers
    logic [DW-1:0] mp1, mp2;   // expected peaks
    bit            pend_decay;
    bit            rand_decay;
    exp_t          e;

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Monitor: outputs seen here reflect the preceding rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            ms1 = '0; ms2 = '0; mp1 = '0; mp2 = '0; pend_decay = 1'b0;
        end else begin
`ifdef ADC_SEQ_PEAK_EN
            if (pend_decay) begin
                mp1 = (mp1 == '0) ? '0 : mp1 - 1'b1;
                mp2 = (mp2 == '0) ? '0 : mp2 - 1'b1;
            end
`endif
            if (ch1_valid && ch2_valid) chk("both_valid", 32'd1, 32'd0);
            if (ch1_valid || ch2_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_channel", 32'(ch1_valid), 32'(e.sel));
                    chk("valid_latency", 32'(cyc), 32'(e.due));
                    if (e.sel) begin
                        ms1 = e.data;
`ifdef ADC_SEQ_PEAK_EN
                        mp1 = max2(e.data, mp1);
`endif
                    end else begin
                        ms2 = e.data;
`ifdef ADC_SEQ_PEAK_EN
                        mp2 = max2(e.data, mp2);
`endif
                    end
                end
            end
            chk("ch1_sample", 32'(ch1_sample), 32'(ms1));
            chk("ch2_sample", 32'(ch2_sample), 32'(ms2));
            chk("ch1_peak",   32'(ch1_peak),   32'(mp1));
            chk("ch2_peak",   32'(ch2_peak),   32'(mp2));
            pend_decay = peak_decay;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        peak_decay = rand_decay ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        exp_ovr = 0; exp_terr = 0;
        chk("err_clr_overrun", 32'(overrun), 32'd0);
        chk("err_clr_timeout", 32'(timeout_err), 32'd0);
    endtask

    // One conversion request. dly = cycles from conv_start to conv_done
    // (1..TO), 0 = never answer. cap_dec >= 0 forces peak_decay on the capture edge.
    task automatic do_conv(input logic [1:0] m, input int dly, input logic [DW-1:0] d,
                           input bit poke, input int cap_dec);
        logic es;
        int   s;
        bit   clr;
        mode = m;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        if (m == MODE_HOLD) begin
            repeat (3) begin
                chk("hold_no_start", 32'(conv_if.conv_start), 32'd0);
                step();
            end
            return;
        end
        s  = cyc;
        es = (m == MODE_CH1) ? 1'b1 : (m == MODE_CH2) ? 1'b0 : nxt;
        chk("tick_to_start", 32'(conv_if.conv_start), 32'd1);
        chk("conv_sel_start", 32'(conv_if.conv_sel), 32'(es));
        mode = 2'($urandom_range(0, 3));   // must not affect the in-flight channel
        step();
        chk("start_one_cycle", 32'(conv_if.conv_start), 32'd0);
        if (poke) begin
            clr = 1'($urandom_range(0, 1));
            sample_tick = 1'b1;
            err_clr = clr;
            step();
            sample_tick = 1'b0;
            err_clr = 1'b0;
            exp_ovr = 1;
            if (clr) exp_terr = 0;
            chk("overrun_set", 32'(overrun), 32'd1);
            chk("timeout_vs_clr", 32'(timeout_err), 32'(exp_terr));
            chk("no_restart", 32'(conv_if.conv_start), 32'd0);
        end
        if (dly == 0) begin
            while (cyc < s + TO) begin
                chk("sel_stable", 32'(conv_if.conv_sel), 32'(es));
                step();
            end
            chk("timeout_not_early", 32'(timeout_err), 32'(exp_terr));
            step();
            chk("timeout_set", 32'(timeout_err), 32'd1);
            chk("timeout_no_start", 32'(conv_if.conv_start), 32'd0);
            exp_terr = 1;
        end else begin
            while (cyc < s + dly) begin
                chk("sel_stable", 32'(conv_if.conv_sel), 32'(es));
                step();
            end
            conv_if.conv_done = 1'b1;
            conv_if.conv_data = d;
            exp_q.push_back('{sel: es, data: d, due: cyc + 2});
            step();
            conv_if.conv_done = 1'b0;
            conv_if.conv_data = DW'($urandom);
            chk("sel_capture", 32'(conv_if.conv_sel), 32'(es));
            if (cap_dec >= 0) peak_decay = cap_dec[0];
            step();
        end
        if (m == MODE_ALT) nxt = ~nxt;
        chk("overrun_flag", 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic check_reset_values();
        chk("rst_conv_start", 32'(conv_if.conv_start), 32'd0);
        chk("rst_conv_sel", 32'(conv_if.conv_sel), 32'd1);
        chk("rst_ch1_sample", 32'(ch1_sample), 32'd0);
        chk("rst_ch2_sample", 32'(ch2_sample), 32'd0);
        chk("rst_valid", 32'({ch1_valid, ch2_valid}), 32'd0);
        chk("rst_errors", 32'({overrun, timeout_err}), 32'd0);
        chk("rst_peaks", 32'({ch1_peak, ch2_peak}), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] exp_pk;
        reset_n = 1'b0; sample_tick = 1'b0; mode = MODE_CH1; err_clr = 1'b0;
        peak_decay = 1'b0; conv_if.conv_done = 1'b0; conv_if.conv_data = '0;
        nxt = 1'b1; exp_ovr = 0; exp_terr = 0; rand_decay = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        reset_n = 1'b1;
        step();

        // Peak directed: decay at zero, then 0x800, 0x400, 0x7FF with decay on capture
        peak_decay = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        peak_decay = 1'b0;
        chk("peak_decay_at_zero", 32'(ch1_peak), 32'd0);
        do_conv(MODE_CH1, 3, 12'h800, 0, 0);
        do_conv(MODE_CH1, 3, 12'h400, 0, 0);
`ifdef ADC_SEQ_PEAK_EN
        exp_pk = 12'h800;
`else
        exp_pk = 12'h000;
`endif
        chk("peak_hold", 32'(ch1_peak), 32'(exp_pk));
        do_conv(MODE_CH1, 3, 12'h7FF, 0, 1);
`ifdef ADC_SEQ_PEAK_EN
        exp_pk = 12'h7FF;
`endif
        chk("peak_decay_capture", 32'(ch1_peak), 32'(exp_pk));

        // Single channel, done 5 cycles after conv_start
        do_conv(MODE_CH1, 5, 12'hABC, 0, -1);
        chk("ch1_abc", 32'(ch1_sample), 32'hABC);

        // Alternate: channel sequence 1,0,1 (nxt is still ch1 here)
        do_conv(MODE_ALT, 4, 12'h100, 0, -1);
        do_conv(MODE_ALT, 4, 12'h200, 0, -1);
        do_conv(MODE_ALT, 4, 12'h300, 0, -1);
        chk("alt_ch1", 32'(ch1_sample), 32'h300);
        chk("alt_ch2", 32'(ch2_sample), 32'h200);

        // Timeout then clear; overrun during WAIT then clear
        do_conv(MODE_CH2, 0, '0, 0, -1);
        clear_err();
        do_conv(MODE_CH2, 6, 12'h055, 1, -1);
        clear_err();
        do_conv(MODE_CH1, TO, 12'hFFF, 0, -1);   // done in the last WAIT cycle

        // Randomized traffic
        rand_decay = 1;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            int dly;
            m   = 2'($urandom_range(0, 3));
            dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
            do_conv(m, dly, DW'($urandom), ((dly == 0 || dly >= 3) && $urandom_range(0, 3) == 0), -1);
            if ($urandom_range(0, 3) == 0) clear_err();
            if ($urandom_range(0, 4) == 0) begin
                conv_if.conv_done = 1'b1;   // stray done while idle
                step();
                conv_if.conv_done = 1'b0;
                step();
            end
        end
        rand_decay = 0;
        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset during WAIT, then a late conv_done must be ignored
        mode = MODE_ALT;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        check_reset_values();
        step();
        reset_n = 1'b1;
        nxt = 1'b1; exp_ovr = 0; exp_terr = 0;
        conv_if.conv_done = 1'b1;
        step();
        conv_if.conv_done = 1'b0;
        repeat (4) step();
        check_reset_values();
        do_conv(MODE_ALT, 2, 12'h321, 0, -1);   // alternate restarts on ch1

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
